// File: rtl/gate_check_pkg.sv
// Shared definitions for the two-input gate response checker and its stimulus side.
// Holds the FSM state encoding, counter width and common truth-table constants.
// Truth tables are indexed by {a,b}: bit 0 is a=0,b=0 and bit 3 is a=1,b=1.
package gate_check_pkg;

   localparam int CNT_W = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      DONE   = 2'd2
   } state_t;

   localparam logic [3:0] NOR_TT = 4'b0001;
   localparam logic [3:0] AND_TT = 4'b1000;
   localparam logic [3:0] OR_TT  = 4'b1110;
   localparam logic [3:0] XOR_TT = 4'b0110;

   // Expected gate output for the given {a,b} under truth table tt.
   function automatic logic tt_lookup(input logic [3:0] tt, input logic [1:0] ab);
      return tt[ab];
   endfunction

endpackage

// File: rtl/settle_counter.sv
// Loadable down-counter with zero flag; counts down to 0 and holds there.
// Latency: load takes effect on the loading edge, o_zero is registered-state decode.
// Backpressure: none; i_load always wins over the decrement.
//
// Ports:
//   i_clk, i_reset  clock and synchronous active-high reset (count -> 0)
//   i_load          load i_load_val on this edge
//   i_load_val      value to load
//   o_zero          count is zero
module settle_counter
   import gate_check_pkg::*;
#(
   parameter int W = CNT_W
) (
   input  logic         i_clk,
   input  logic         i_reset,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   output logic         o_zero
);

   logic [W-1:0] r_count;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (r_count != '0) begin
         r_count <= r_count - 1'b1;
      end
   end

   assign o_zero = (r_count == '0);

endmodule

// File: rtl/gate_response_checker.sv
// Checks a two-input gate: accepts an {a,b} record, waits SETTLE_CYCLES, compares y to TRUTH_TABLE.
// Latency: accept at edge T, y sampled and counters updated at edge T+SETTLE_CYCLES.
// Backpressure: in_rdy only in IDLE; one vector per SETTLE_CYCLES+1 cycles, none after done.
//
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   in_val/in_rdy     stimulus record handshake; in_a/in_b are the applied stimulus
//   dut_y             gate output under check
//   pass_count        vectors that matched, fail_count vectors that mismatched
//   first_fail_val    first_fail_vec holds {a,b,y} of the earliest failing vector
//   done              NUM_VECTORS vectors checked; frozen until reset
module gate_response_checker
   import gate_check_pkg::*;
#(
   parameter logic [3:0] TRUTH_TABLE   = NOR_TT,
   parameter int         SETTLE_CYCLES = 9,
   parameter int         NUM_VECTORS   = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_val,
   output logic             in_rdy,
   input  logic             in_a,
   input  logic             in_b,
   input  logic             dut_y,
   output logic [CNT_W-1:0] pass_count,
   output logic [CNT_W-1:0] fail_count,
   output logic             first_fail_val,
   output logic [2:0]       first_fail_vec,
   output logic             done
);

   localparam logic [CNT_W-1:0] LP_SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] LP_NUM_VEC     = CNT_W'(NUM_VECTORS);

   state_t           r_state;
   state_t           w_next_state;
   logic [1:0]       r_ab;
   logic [CNT_W-1:0] r_pass;
   logic [CNT_W-1:0] r_fail;
   logic [CNT_W-1:0] r_vec_cnt;
   logic             r_ff_val;
   logic [2:0]       r_ff_vec;

   logic             w_accept;
   logic             w_zero;
   logic             w_sample;
   logic             w_match;
   logic [CNT_W-1:0] w_vec_next;
   logic             w_last;

   assign w_accept   = (r_state == IDLE) && in_val;
   assign w_sample   = (r_state == SETTLE) && w_zero;
   assign w_match    = (dut_y == tt_lookup(TRUTH_TABLE, r_ab));
   assign w_vec_next = r_vec_cnt + 1'b1;
   assign w_last     = (w_vec_next == LP_NUM_VEC);

   // Loaded with SETTLE_CYCLES-1 so the zero flag lines up with edge T+SETTLE_CYCLES.
   settle_counter #(.W(CNT_W)) u_settle (
      .i_clk      (clk),
      .i_reset    (reset),
      .i_load     (w_accept),
      .i_load_val (LP_SETTLE_LOAD),
      .o_zero     (w_zero)
   );

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:    if (in_val) w_next_state = SETTLE;
         SETTLE:  if (w_zero) w_next_state = w_last ? DONE : IDLE;
         DONE:    w_next_state = DONE;
         default: w_next_state = IDLE;
      endcase
   end

   // Outputs decoded from registered state only
   always_comb begin
      in_rdy = 1'b0;
      done   = 1'b0;
      case (r_state)
         IDLE:    in_rdy = 1'b1;
         DONE:    done   = 1'b1;
         default: ;
      endcase
   end

   // Stimulus capture and scoreboard; a/b are held so live input changes during SETTLE are ignored.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_ab      <= 2'b00;
         r_pass    <= '0;
         r_fail    <= '0;
         r_vec_cnt <= '0;
         r_ff_val  <= 1'b0;
         r_ff_vec  <= 3'b000;
      end else begin
         if (w_accept) begin
            r_ab <= {in_a, in_b};
         end
         if (w_sample) begin
            r_vec_cnt <= w_vec_next;
            if (w_match) begin
               r_pass <= r_pass + 1'b1;
            end else begin
               r_fail <= r_fail + 1'b1;
               if (!r_ff_val) begin
                  r_ff_val <= 1'b1;
                  r_ff_vec <= {r_ab, dut_y};
               end
            end
         end
      end
   end

   assign pass_count     = r_pass;
   assign fail_count     = r_fail;
   assign first_fail_val = r_ff_val;
   assign first_fail_vec = r_ff_vec;

endmodule

// File: tb/tb_gate_response_checker.sv
// Directed bench for gate_response_checker over three parameterisations:
//   0: default NOR, SETTLE=9    1: XOR table, SETTLE=9    2: NOR, SETTLE=3
// Inputs driven and outputs sampled on the falling edge.
module tb_gate_response_checker;
   import gate_check_pkg::*;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst  [3];
   logic       val  [3];
   logic       a    [3];
   logic       b    [3];
   logic       y    [3];
   logic       rdy  [3];
   logic       ffv  [3];
   logic       dn   [3];
   logic [7:0] pc   [3];
   logic [7:0] fc   [3];
   logic [2:0] fvec [3];

   int checks = 0;
   int errors = 0;

   gate_response_checker u_nor (
      .clk(clk), .reset(rst[0]), .in_val(val[0]), .in_rdy(rdy[0]), .in_a(a[0]), .in_b(b[0]),
      .dut_y(y[0]), .pass_count(pc[0]), .fail_count(fc[0]), .first_fail_val(ffv[0]),
      .first_fail_vec(fvec[0]), .done(dn[0]));

   gate_response_checker #(.TRUTH_TABLE(XOR_TT)) u_xor (
      .clk(clk), .reset(rst[1]), .in_val(val[1]), .in_rdy(rdy[1]), .in_a(a[1]), .in_b(b[1]),
      .dut_y(y[1]), .pass_count(pc[1]), .fail_count(fc[1]), .first_fail_val(ffv[1]),
      .first_fail_vec(fvec[1]), .done(dn[1]));

   gate_response_checker #(.SETTLE_CYCLES(3)) u_s3 (
      .clk(clk), .reset(rst[2]), .in_val(val[2]), .in_rdy(rdy[2]), .in_a(a[2]), .in_b(b[2]),
      .dut_y(y[2]), .pass_count(pc[2]), .fail_count(fc[2]), .first_fail_val(ffv[2]),
      .first_fail_vec(fvec[2]), .done(dn[2]));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset(input int k, input string tag);
      chk({tag, ":rdy"},   rdy[k],  32'd1);
      chk({tag, ":pass"},  pc[k],   32'd0);
      chk({tag, ":fail"},  fc[k],   32'd0);
      chk({tag, ":ffv"},   ffv[k],  32'd0);
      chk({tag, ":fvec"},  fvec[k], 32'd0);
      chk({tag, ":done"},  dn[k],   32'd0);
   endtask

   // Ends on a falling edge with reset released.
   task automatic do_reset(input int k);
      @(negedge clk);
      rst[k] = 1'b1;
      val[k] = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst[k] = 1'b0;
   endtask

   // Entered on a falling edge. y starts at y_early and becomes y_final after
   // edge T+sw (sw=0: y_final from the start). Ends on the falling edge after T+s.
   task automatic run_vec(input int k, input int s, input logic av, input logic bv,
                          input logic y_early, input logic y_final, input int sw,
                          input int exp_p, input int exp_f, input string tag);
      chk({tag, ":rdy_idle"}, rdy[k], 32'd1);
      val[k] = 1'b1;
      a[k]   = av;
      b[k]   = bv;
      y[k]   = (sw == 0) ? y_final : y_early;
      @(posedge clk);
      @(negedge clk);
      val[k] = 1'b0;
      chk({tag, ":rdy_settle"}, rdy[k], 32'd0);
      for (int i = 1; i <= s; i++) begin
         if (i == s) chk({tag, ":pre_sample"}, pc[k] + fc[k], exp_p + exp_f - 1);
         @(posedge clk);
         @(negedge clk);
         if (i == sw) y[k] = y_final;
      end
      chk({tag, ":pass"}, pc[k], exp_p);
      chk({tag, ":fail"}, fc[k], exp_f);
      chk({tag, ":done"}, dn[k], ((exp_p + exp_f) == 4) ? 32'd1 : 32'd0);
   endtask

   initial begin
      for (int k = 0; k < 3; k++) begin
         rst[k] = 1'b1; val[k] = 1'b0; a[k] = 1'b0; b[k] = 1'b0; y[k] = 1'b0;
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_reset(0, "rst_nor");
      chk_reset(1, "rst_xor");
      chk_reset(2, "rst_s3");
      for (int k = 0; k < 3; k++) rst[k] = 1'b0;

      // Good NOR, y = ~(a|b)
      run_vec(0, 9, 1'b0, 1'b0, 1'b1, 1'b1, 0, 1, 0, "t1_00");
      run_vec(0, 9, 1'b0, 1'b1, 1'b0, 1'b0, 0, 2, 0, "t1_01");
      run_vec(0, 9, 1'b1, 1'b0, 1'b0, 1'b0, 0, 3, 0, "t1_10");
      run_vec(0, 9, 1'b1, 1'b1, 1'b0, 1'b0, 0, 4, 0, "t1_11");
      chk("t1_ffv", ffv[0], 32'd0);

      // Stuck-at-0 DUT
      do_reset(0);
      chk_reset(0, "t2_rst");
      run_vec(0, 9, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1, "t2_00");
      run_vec(0, 9, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1, 1, "t2_01");
      run_vec(0, 9, 1'b1, 1'b0, 1'b0, 1'b0, 0, 2, 1, "t2_10");
      run_vec(0, 9, 1'b1, 1'b1, 1'b0, 1'b0, 0, 3, 1, "t2_11");
      chk("t2_ffv",  ffv[0],  32'd1);
      chk("t2_fvec", fvec[0], 32'b000);

      // Reset in SETTLE of vector 2, then clean rerun
      do_reset(0);
      run_vec(0, 9, 1'b0, 1'b1, 1'b1, 1'b1, 0, 0, 1, "t6_v1");
      val[0] = 1'b1; a[0] = 1'b1; b[0] = 1'b1; y[0] = 1'b0;
      @(posedge clk);
      @(negedge clk);
      val[0] = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst[0] = 1'b0;
      chk_reset(0, "t6_rst");
      run_vec(0, 9, 1'b0, 1'b0, 1'b1, 1'b1, 0, 1, 0, "t6_00");
      run_vec(0, 9, 1'b0, 1'b1, 1'b0, 1'b0, 0, 2, 0, "t6_01");
      run_vec(0, 9, 1'b1, 1'b0, 1'b0, 1'b0, 0, 3, 0, "t6_10");
      run_vec(0, 9, 1'b1, 1'b1, 1'b0, 1'b0, 0, 4, 0, "t6_11");

      // XOR table, DUT is OR: only the last vector fails
      @(negedge clk);
      run_vec(1, 9, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1, 0, "t3_00");
      run_vec(1, 9, 1'b0, 1'b1, 1'b1, 1'b1, 0, 2, 0, "t3_01");
      run_vec(1, 9, 1'b1, 1'b0, 1'b1, 1'b1, 0, 3, 0, "t3_10");
      run_vec(1, 9, 1'b1, 1'b1, 1'b1, 1'b1, 0, 3, 1, "t3_11");
      chk("t3_ffv",  ffv[1],  32'd1);
      chk("t3_fvec", fvec[1], 32'b111);

      // DONE is frozen: further valid records are ignored
      val[1] = 1'b1; a[1] = 1'b0; b[1] = 1'b0; y[1] = 1'b1;
      repeat (12) @(posedge clk);
      @(negedge clk);
      val[1] = 1'b0;
      chk("frz_pass", pc[1],   32'd3);
      chk("frz_fail", fc[1],   32'd1);
      chk("frz_rdy",  rdy[1],  32'd0);
      chk("frz_done", dn[1],   32'd1);
      chk("frz_fvec", fvec[1], 32'b111);

      // SETTLE=3, y correct from 3 cycles after the stimulus: all pass
      @(negedge clk);
      run_vec(2, 3, 1'b0, 1'b0, 1'b0, 1'b1, 2, 1, 0, "t4a_00");
      run_vec(2, 3, 1'b0, 1'b1, 1'b1, 1'b0, 2, 2, 0, "t4a_01");
      run_vec(2, 3, 1'b1, 1'b0, 1'b1, 1'b0, 2, 3, 0, "t4a_10");
      run_vec(2, 3, 1'b1, 1'b1, 1'b1, 1'b0, 2, 4, 0, "t4a_11");

      // y correct only from 4 cycles after: all fail, first failure kept
      do_reset(2);
      run_vec(2, 3, 1'b0, 1'b0, 1'b0, 1'b1, 3, 0, 1, "t4b_00");
      run_vec(2, 3, 1'b0, 1'b1, 1'b1, 1'b0, 3, 0, 2, "t4b_01");
      run_vec(2, 3, 1'b1, 1'b0, 1'b1, 1'b0, 3, 0, 3, "t4b_10");
      run_vec(2, 3, 1'b1, 1'b1, 1'b1, 1'b0, 3, 0, 4, "t4b_11");
      chk("t4b_fvec", fvec[2], 32'b000);

      // in_val held high, a/b toggled during SETTLE
      do_reset(2);
      val[2] = 1'b1; a[2] = 1'b0; b[2] = 1'b0; y[2] = 1'b1;
      @(posedge clk);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("t5_rdy_v1", rdy[2], 32'd0);
         a[2] = ~a[2];
         b[2] = ~b[2];
         @(posedge clk);
      end
      @(negedge clk);
      chk("t5_pass1", pc[2],  32'd1);
      chk("t5_fail1", fc[2],  32'd0);
      chk("t5_rdy1",  rdy[2], 32'd1);
      a[2] = 1'b1; b[2] = 1'b1; y[2] = 1'b0;
      @(posedge clk);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("t5_rdy_v2", rdy[2], 32'd0);
         a[2] = ~a[2];
         b[2] = ~b[2];
         @(posedge clk);
      end
      @(negedge clk);
      val[2] = 1'b0;
      chk("t5_pass2", pc[2],  32'd2);
      chk("t5_fail2", fc[2],  32'd0);
      chk("t5_rdy2",  rdy[2], 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
